// File: rtl/button_event_ctrl.sv
// Per-channel press/auto-repeat event generator with a round-robin valid/ready event port.
// Optional BUTTON_RELEASE_EVT_EN adds release events on the falling edge of a held button.
module button_event_ctrl #(
    parameter int WIDTH          = 4,
    parameter int HOLD_CNT_MAX   = 500000,
    parameter int REPEAT_CNT_MAX = 125000,
    parameter int ID_WIDTH       = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int TMR_WIDTH      = $clog2(HOLD_CNT_MAX) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    btn_in,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [ID_WIDTH-1:0] evt_id,
    output logic                evt_repeat,
    output logic                evt_release,
    output logic [WIDTH-1:0]    pending,
    output logic                dropped
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [TMR_WIDTH-1:0] HOLD_LOAD = TMR_WIDTH'(HOLD_CNT_MAX - 1);
    localparam logic [TMR_WIDTH-1:0] REP_LOAD  = TMR_WIDTH'(REPEAT_CNT_MAX - 1);

    logic [WIDTH-1:0]     r_btn_prev;
    logic [WIDTH-1:0]     w_rise;
    logic [1:0]           r_state     [WIDTH];
    logic [1:0]           w_state_nxt [WIDTH];
    logic [TMR_WIDTH-1:0] r_tmr       [WIDTH];
    logic [TMR_WIDTH-1:0] w_tmr_nxt   [WIDTH];
    logic [WIDTH-1:0]     w_post;
    logic [WIDTH-1:0]     w_post_rep;
    logic [WIDTH-1:0]     r_pending;
    logic [WIDTH-1:0]     w_pending_nxt;
    logic [WIDTH-1:0]     r_kind_rep;
    logic [WIDTH-1:0]     w_kind_rep_nxt;
    logic [WIDTH-1:0]     w_drop;
    logic [WIDTH-1:0]     w_loaded;
    logic [ID_WIDTH-1:0]  w_idx;
    logic [ID_WIDTH-1:0]  w_sel;
    logic [ID_WIDTH-1:0]  w_rr_nxt;
    logic                 w_any;
    logic                 w_load_slot;
    logic                 r_evt_valid;
    logic [ID_WIDTH-1:0]  r_evt_id;
    logic                 r_evt_repeat;
    logic                 r_dropped;
    logic [ID_WIDTH-1:0]  r_rr_ptr;
`ifdef BUTTON_RELEASE_EVT_EN
    logic [WIDTH-1:0]     w_post_rel;
    logic [WIDTH-1:0]     r_kind_rel;
    logic [WIDTH-1:0]     w_kind_rel_nxt;
    logic                 r_evt_release;
`endif

    function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base, input int offset);
        int v_sum;
        v_sum = (int'(base) + offset) % WIDTH;
        return ID_WIDTH'(v_sum);
    endfunction

    assign w_rise      = btn_in & ~r_btn_prev;
    assign w_load_slot = ~r_evt_valid | evt_ready;

    // Per-channel press/hold/repeat state machine and timer
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_tmr_nxt[i]   = r_tmr[i];
            w_post[i]      = 1'b0;
            w_post_rep[i]  = 1'b0;
`ifdef BUTTON_RELEASE_EVT_EN
            w_post_rel[i]  = 1'b0;
`endif
            case (r_state[i])
                ST_IDLE: begin
                    if (w_rise[i]) begin
                        w_post[i]      = 1'b1;
                        w_tmr_nxt[i]   = HOLD_LOAD;
                        w_state_nxt[i] = ST_HELD;
                    end else begin
                        w_tmr_nxt[i]   = {TMR_WIDTH{1'b0}};
                    end
                end
                ST_HELD, ST_REPEAT: begin
                    if (!btn_in[i]) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_tmr_nxt[i]   = {TMR_WIDTH{1'b0}};
`ifdef BUTTON_RELEASE_EVT_EN
                        w_post[i]      = 1'b1;
                        w_post_rel[i]  = 1'b1;
`endif
                    end else if (r_tmr[i] == {TMR_WIDTH{1'b0}}) begin
                        w_post[i]      = 1'b1;
                        w_post_rep[i]  = 1'b1;
                        w_tmr_nxt[i]   = REP_LOAD;
                        w_state_nxt[i] = ST_REPEAT;
                    end else begin
                        w_tmr_nxt[i]   = r_tmr[i] - TMR_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_tmr_nxt[i]   = {TMR_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Round-robin pick of the first pending channel at or after the pointer
    always_comb begin
        w_any = 1'b0;
        w_sel = {ID_WIDTH{1'b0}};
        w_idx = {ID_WIDTH{1'b0}};
        for (int k = 0; k < WIDTH; k++) begin
            w_idx = rr_index(r_rr_ptr, k);
            if (!w_any && r_pending[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end else begin
                w_any = w_any;
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_loaded[i] = w_load_slot & w_any & (w_sel == ID_WIDTH'(i));
        end
        w_rr_nxt = (w_sel == ID_WIDTH'(WIDTH - 1)) ? {ID_WIDTH{1'b0}} : w_sel + ID_WIDTH'(1);
    end

    // A loaded channel hands its old event to the output, so a same-cycle post is not a drop
    always_comb begin
        w_pending_nxt  = r_pending;
        w_kind_rep_nxt = r_kind_rep;
        w_drop         = {WIDTH{1'b0}};
`ifdef BUTTON_RELEASE_EVT_EN
        w_kind_rel_nxt = r_kind_rel;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (w_post[i]) begin
                if (r_pending[i] && !w_loaded[i]) begin
                    w_drop[i] = 1'b1;
                end else begin
                    w_pending_nxt[i]  = 1'b1;
                    w_kind_rep_nxt[i] = w_post_rep[i];
`ifdef BUTTON_RELEASE_EVT_EN
                    w_kind_rel_nxt[i] = w_post_rel[i];
`endif
                end
            end else if (w_loaded[i]) begin
                w_pending_nxt[i] = 1'b0;
            end else begin
                w_pending_nxt[i] = r_pending[i];
            end
        end
    end

    // State, pending capture and registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_prev   <= {WIDTH{1'b0}};
            r_pending    <= {WIDTH{1'b0}};
            r_kind_rep   <= {WIDTH{1'b0}};
            r_evt_valid  <= 1'b0;
            r_evt_id     <= {ID_WIDTH{1'b0}};
            r_evt_repeat <= 1'b0;
            r_dropped    <= 1'b0;
            r_rr_ptr     <= {ID_WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_IDLE;
                r_tmr[i]   <= {TMR_WIDTH{1'b0}};
            end
`ifdef BUTTON_RELEASE_EVT_EN
            r_kind_rel    <= {WIDTH{1'b0}};
            r_evt_release <= 1'b0;
`endif
        end else begin
            r_btn_prev <= btn_in;
            r_pending  <= w_pending_nxt;
            r_kind_rep <= w_kind_rep_nxt;
            r_dropped  <= |w_drop;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tmr[i]   <= w_tmr_nxt[i];
            end
`ifdef BUTTON_RELEASE_EVT_EN
            r_kind_rel <= w_kind_rel_nxt;
`endif
            if (w_load_slot) begin
                r_evt_valid <= w_any;
                if (w_any) begin
                    r_evt_id     <= w_sel;
                    r_evt_repeat <= r_kind_rep[w_sel];
                    r_rr_ptr     <= w_rr_nxt;
`ifdef BUTTON_RELEASE_EVT_EN
                    r_evt_release <= r_kind_rel[w_sel];
`endif
                end
            end
        end
    end

    assign evt_valid  = r_evt_valid;
    assign evt_id     = r_evt_id;
    assign evt_repeat = r_evt_repeat;
    assign pending    = r_pending;
    assign dropped    = r_dropped;
`ifdef BUTTON_RELEASE_EVT_EN
    assign evt_release = r_evt_release;
`else
    assign evt_release = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: elapsed-time reference model, per-cycle comparison,
// directed scenarios with literal expectations, then randomized button/ready traffic.
module tb_button_event_ctrl;

    localparam int W    = 4;
    localparam int HOLD = 10;
    localparam int REP  = 4;
`ifdef BUTTON_RELEASE_EVT_EN
    localparam int EXP_DROP_EVTS = 3;
    localparam int EXP_T6_TOTAL  = 2;
    localparam int EXP_T6_REL    = 1;
`else
    localparam int EXP_DROP_EVTS = 2;
    localparam int EXP_T6_TOTAL  = 1;
    localparam int EXP_T6_REL    = 0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] btn_in;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_id;
    logic         evt_repeat;
    logic         evt_release;
    logic [W-1:0] pending;
    logic         dropped;

    button_event_ctrl #(.WIDTH(W), .HOLD_CNT_MAX(HOLD), .REPEAT_CNT_MAX(REP)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_repeat(evt_repeat), .evt_release(evt_release),
        .pending(pending), .dropped(dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // reference model state: per-channel press time instead of a countdown
    bit m_held [W];
    int m_t0   [W];
    bit m_prev [W];
    bit m_pend [W];
    bit m_krep [W];
    bit m_krel [W];
    bit m_valid, m_rep, m_rel, m_drop;
    int m_id, m_rr;

    int cnt_press [W];
    int cnt_rep   [W];
    int cnt_rel   [W];
    int q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_held[i] = 0; m_t0[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_krep[i] = 0; m_krel[i] = 0;
        end
        m_valid = 0; m_rep = 0; m_rel = 0; m_drop = 0; m_id = 0; m_rr = 0;
    endtask

    task automatic model_step();
        int loaded, kind, e, c;
        bit found;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            loaded = -1;
            if (!m_valid || evt_ready) begin
                found = 0;
                for (int k = 0; k < W; k++) begin
                    c = (m_rr + k) % W;
                    if (!found && m_pend[c]) begin found = 1; loaded = c; end
                end
                m_valid = found;
                if (found) begin
                    m_id = loaded; m_rep = m_krep[loaded]; m_rel = m_krel[loaded];
                    m_rr = (loaded + 1) % W;
                end
            end
            m_drop = 0;
            for (int i = 0; i < W; i++) begin
                kind = 0;  // 1 press, 2 repeat, 3 release
                if (!m_held[i]) begin
                    if (btn_in[i] && !m_prev[i]) begin kind = 1; m_held[i] = 1; m_t0[i] = cyc; end
                end else if (!btn_in[i]) begin
                    m_held[i] = 0;
`ifdef BUTTON_RELEASE_EVT_EN
                    kind = 3;
`endif
                end else begin
                    e = cyc - m_t0[i];
                    if (e >= HOLD && (e - HOLD) % REP == 0) kind = 2;
                end
                if (kind != 0) begin
                    if (m_pend[i] && loaded != i) m_drop = 1;
                    else begin m_pend[i] = 1; m_krep[i] = (kind == 2); m_krel[i] = (kind == 3); end
                end else if (loaded == i) begin
                    m_pend[i] = 0;
                end
                m_prev[i] = btn_in[i];
            end
        end
    endtask

    task automatic compare_cycle();
        logic [9:0] ev, av;
        logic [3:0] mp;
        if (!rst) begin
            for (int i = 0; i < W; i++) mp[i] = m_pend[i];
            ev = {m_valid, m_valid ? 2'(m_id) : 2'b00, m_valid & m_rep, m_valid & m_rel, mp, m_drop};
            av = {evt_valid, evt_valid ? evt_id : 2'b00, evt_valid & evt_repeat,
                  evt_valid & evt_release, pending, dropped};
            check("cycle_model", 32'(av), 32'(ev));
        end
    endtask

    // one clock: log a DUT handshake, advance the model at the edge, compare on the falling edge
    task automatic tick();
        if (!rst && evt_valid && evt_ready) begin
            if (evt_release)     cnt_rel[evt_id]++;
            else if (evt_repeat) cnt_rep[evt_id]++;
            else                 cnt_press[evt_id]++;
            if (evt_id == 2'd1) q1.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_in = '0; evt_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    int b_press, b_rep, b_rel, b_press3, b_qs, t6_total, t6_rel;

    initial begin
        rst = 1'b1; btn_in = '0; evt_ready = 1'b0;
        model_reset();
        for (int i = 0; i < W; i++) begin cnt_press[i] = 0; cnt_rep[i] = 0; cnt_rel[i] = 0; end
        repeat (2) tick();
        check("reset_state", 32'({evt_valid, evt_id, evt_repeat, evt_release, pending, dropped}), 32'd0);
        rst = 1'b0;
        tick();

        // single press on ch2
        evt_ready = 1'b1; b_press = cnt_press[2];
        btn_in[2] = 1'b1;
        tick();
        check("t1_pending", 32'({evt_valid, pending}), 32'({1'b0, 4'b0100}));
        tick();
        check("t1_event", 32'({evt_valid, evt_id, evt_repeat, pending}), 32'({1'b1, 2'd2, 1'b0, 4'b0000}));
        tick();
        check("t1_one_cycle", 32'(evt_valid), 32'd0);
        btn_in[2] = 1'b0;
        repeat (4) tick();
        check("t1_count", 32'(cnt_press[2] - b_press), 32'd1);

        // hold ch1 for 25 cycles after the press post
        b_press = cnt_press[1]; b_rep = cnt_rep[1]; b_qs = q1.size();
        btn_in[1] = 1'b1;
        repeat (25) tick();
        btn_in[1] = 1'b0;
        repeat (8) tick();
        check("t2_press", 32'(cnt_press[1] - b_press), 32'd1);
        check("t2_repeats", 32'(cnt_rep[1] - b_rep), 32'd4);
        if (q1.size() >= b_qs + 5) begin
            check("t2_first_gap", 32'(q1[b_qs+1] - q1[b_qs]), 32'd10);
            check("t2_rep_gap_a", 32'(q1[b_qs+2] - q1[b_qs+1]), 32'd4);
            check("t2_rep_gap_b", 32'(q1[b_qs+4] - q1[b_qs+3]), 32'd4);
        end else begin
            check("t2_event_log", 32'(q1.size() - b_qs), 32'd5);
        end

        // contention ch0/ch3 with ready low
        do_reset();
        b_press = cnt_press[0]; b_press3 = cnt_press[3];
        btn_in = 4'b1001;
        tick();
        check("t3_pending", 32'({evt_valid, pending}), 32'({1'b0, 4'b1001}));
        tick();
        check("t3_first", 32'({evt_valid, evt_id, pending}), 32'({1'b1, 2'd0, 4'b1000}));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_stable", 32'({evt_valid, evt_id, evt_repeat}), 32'({1'b1, 2'd0, 1'b0}));
        end
        evt_ready = 1'b1;
        tick();
        check("t3_second", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd3}));
        tick();
        check("t3_drained", 32'(evt_valid), 32'd0);
        btn_in = '0;
        repeat (6) tick();
        check("t3_counts", 32'({16'(cnt_press[0] - b_press), 16'(cnt_press[3] - b_press3)}), 32'h0001_0001);

        // drop: ch0 repeat sits pending while its press sits in the output
        do_reset();
        b_press = cnt_press[0] + cnt_rep[0] + cnt_rel[0];
        btn_in[0] = 1'b1;
        repeat (12) tick();
        btn_in[0] = 1'b0;
        tick();
        btn_in[0] = 1'b1;
        tick();
        check("t4_dropped", 32'({dropped, pending[0], evt_valid, evt_id, evt_repeat}), 32'({1'b1, 1'b1, 1'b1, 2'd0, 1'b0}));
        tick();
        check("t4_pulse_end", 32'({dropped, pending[0]}), 32'({1'b0, 1'b1}));
        btn_in[0] = 1'b0; evt_ready = 1'b1;
        repeat (6) tick();
        check("t4_delivered", 32'(cnt_press[0] + cnt_rep[0] + cnt_rel[0] - b_press), 32'(EXP_DROP_EVTS));

        // async reset while ch1 is repeating and an event is presented
        do_reset();
        btn_in[1] = 1'b1;
        repeat (12) tick();
        check("t5_before", 32'(evt_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_cleared", 32'({evt_valid, evt_id, evt_repeat, evt_release, pending, dropped}), 32'd0);
        evt_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t5_new_press", 32'({evt_valid, evt_id, evt_repeat}), 32'({1'b1, 2'd1, 1'b0}));
        btn_in[1] = 1'b0;
        repeat (4) tick();

        // press then release ch3
        do_reset();
        evt_ready = 1'b1;
        t6_total = cnt_press[3] + cnt_rep[3] + cnt_rel[3]; t6_rel = cnt_rel[3];
        btn_in[3] = 1'b1;
        repeat (3) tick();
        btn_in[3] = 1'b0;
        repeat (5) tick();
        check("t6_events", 32'(cnt_press[3] + cnt_rep[3] + cnt_rel[3] - t6_total), 32'(EXP_T6_TOTAL));
        check("t6_releases", 32'(cnt_rel[3] - t6_rel), 32'(EXP_T6_REL));

        // randomized traffic with one mid-run reset
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 15) == 0) btn_in[i] = ~btn_in[i];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            if (n == 2000) rst = 1'b1;
            if (n == 2003) rst = 1'b0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
